// File: rtl/dout_stream_merger.sv
// Merges four HLS output streams through per-port FIFOs onto one nibble-wide
// framed board output, arbitrated round-robin between ports.
module dout_stream_merger #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic [DATA_W-1:0] D_out_0_din,
  input  logic              D_out_0_write,
  output logic              D_out_0_full_n,
  input  logic [DATA_W-1:0] D_out_1_din,
  input  logic              D_out_1_write,
  output logic              D_out_1_full_n,
  input  logic [DATA_W-1:0] D_out_2_din,
  input  logic              D_out_2_write,
  output logic              D_out_2_full_n,
  input  logic [DATA_W-1:0] D_out_3_din,
  input  logic              D_out_3_write,
  output logic              D_out_3_full_n,
  output logic [3:0]        data_out,
  output logic              data_valid,
  output logic              data_sof,
  input  logic              data_ready,
  output logic [3:0]        overflow,
  output logic              frame_done
);

  localparam int unsigned NPORT = 4;
  localparam int unsigned NIBS  = DATA_W / 4;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned NIB_W = (NIBS > 1) ? $clog2(NIBS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PAY  = 2'd2
  } state_t;

  logic [DATA_W-1:0] din [NPORT];
  logic [NPORT-1:0]  wr;
  logic [NPORT-1:0]  push;
  logic [NPORT-1:0]  pop;
  logic [NPORT-1:0]  nonempty;
  logic [NPORT-1:0]  full;

  logic [DATA_W-1:0] mem    [NPORT][FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr [NPORT];
  logic [PTR_W-1:0]  rd_ptr [NPORT];
  logic [CNT_W-1:0]  count  [NPORT];

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        src;
  logic [1:0]        last;
  logic [1:0]        grant_idx;
  logic [1:0]        cand;
  logic              grant_any;
  logic              grant_take;
  logic              last_nib;
  logic              frame_end;
  logic              pay_xfer;
  logic [DATA_W-1:0] word;
  logic [NIB_W-1:0]  nib_idx;

  assign din[0] = D_out_0_din;
  assign din[1] = D_out_1_din;
  assign din[2] = D_out_2_din;
  assign din[3] = D_out_3_din;
  assign wr     = {D_out_3_write, D_out_2_write, D_out_1_write, D_out_0_write};

  assign D_out_0_full_n = ~full[0];
  assign D_out_1_full_n = ~full[1];
  assign D_out_2_full_n = ~full[2];
  assign D_out_3_full_n = ~full[3];

  // Per-port status from registered counts; full does not look ahead to a pop.
  always_comb begin
    full     = '0;
    nonempty = '0;
    push     = '0;
    pop      = '0;
    for (int k = 0; k < NPORT; k++) begin
      full[k]     = (count[k] == CNT_W'(FIFO_DEPTH));
      nonempty[k] = (count[k] != '0);
      push[k]     = wr[k] && !full[k];
      pop[k]      = frame_end && (src == 2'(k));
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      for (int k = 0; k < NPORT; k++) begin
        count[k]  <= '0;
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
      end
      overflow <= '0;
    end else begin
      for (int k = 0; k < NPORT; k++) begin
        if (push[k]) wr_ptr[k] <= wr_ptr[k] + PTR_W'(1);
        if (pop[k])  rd_ptr[k] <= rd_ptr[k] + PTR_W'(1);
        if (push[k] && !pop[k])      count[k] <= count[k] + CNT_W'(1);
        else if (!push[k] && pop[k]) count[k] <= count[k] - CNT_W'(1);
        if (wr[k] && full[k]) overflow[k] <= 1'b1;
      end
    end
  end

  // Storage needs no reset; validity is tracked by the counts.
  always_ff @(posedge ap_clk) begin
    for (int k = 0; k < NPORT; k++) begin
      if (push[k]) mem[k][wr_ptr[k]] <= din[k];
    end
  end

  // Round-robin search starting after the last served port.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = 2'd0;
    cand      = 2'd0;
    for (int i = 1; i <= NPORT; i++) begin
      cand = last + 2'(i);
      if (!grant_any && nonempty[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_any) state_nxt = HDR;
      HDR:     if (data_ready) state_nxt = PAY;
      PAY:     if (data_ready && last_nib) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Board-side outputs decoded purely from registered frame state.
  always_comb begin
    data_valid = 1'b0;
    data_sof   = 1'b0;
    data_out   = 4'h0;
    case (state)
      HDR: begin
        data_valid = 1'b1;
        data_sof   = 1'b1;
        data_out   = {2'b10, src};
      end
      PAY: begin
        data_valid = 1'b1;
        data_out   = word[DATA_W-1 -: 4];
      end
      default: ;
    endcase
  end

  assign grant_take = (state == IDLE) && grant_any;
  assign last_nib   = (nib_idx == NIB_W'(NIBS - 1));
  assign pay_xfer   = (state == PAY) && data_ready;
  assign frame_end  = pay_xfer && last_nib;

  // Frame datapath: the head word is copied at grant and shifted out MSB first.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      src        <= 2'd0;
      last       <= 2'd3;
      word       <= '0;
      nib_idx    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (grant_take) begin
        src     <= grant_idx;
        word    <= mem[grant_idx][rd_ptr[grant_idx]];
        nib_idx <= '0;
      end else if (pay_xfer) begin
        if (last_nib) begin
          last <= src;
        end else begin
          nib_idx <= nib_idx + NIB_W'(1);
          word    <= word << 4;
        end
      end
    end
  end

endmodule
